// File: rtl/div_scheduler.sv
// div_scheduler: round-robin 2-port front end and cycle sequencer for the shared 8-cycle fraction divider
module div_scheduler #(
  parameter int DW      = 7,
  parameter int FW      = 8,
  parameter int DIV_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [DW-1:0] a_dividend,
  input  logic [DW-1:0] a_divisor,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [DW-1:0] b_dividend,
  input  logic [DW-1:0] b_divisor,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [FW-1:0] res_frac,
  output logic          res_src,
  output logic          res_sat,
  output logic [2:0]    div_cycle_cnt,
  output logic [DW-1:0] div_dividend,
  output logic [DW-1:0] div_divider,
  input  logic [FW-1:0] div_frac_val,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;
  localparam logic [1:0] W_END = 2'(DIV_LAT == 0 ? 0 : DIV_LAT - 1);
  state_t state, state_n;
  logic last_b, gnt_b, acc, sat, byp, byp_q, cap;
  logic [2:0] k;
  logic [1:0] w;
  logic [DW-1:0] dvd, dvs;
  always_comb begin
    gnt_b   = b_valid & (~a_valid | ~last_b);
    a_ready = rst & (state == IDLE) & ~gnt_b;
    b_ready = rst & (state == IDLE) & gnt_b;
    acc     = (a_valid & a_ready) | (b_valid & b_ready);
    dvd     = gnt_b ? b_dividend : a_dividend;
    dvs     = gnt_b ? b_divisor : a_divisor;
    sat     = (dvs == '0) | (dvd >= dvs);
    byp     = sat | (dvd == '0);
    cap     = (state == RUN && k == 3'd7 && DIV_LAT == 0) || (state == WAIT && !byp_q && w == W_END);
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? (byp ? WAIT : RUN) : IDLE;
      RUN:     state_n = (k == 3'd7) ? (DIV_LAT == 0 ? DONE : WAIT) : RUN;
      WAIT:    state_n = (byp_q || w == W_END) ? DONE : WAIT;
      default: state_n = res_ready ? IDLE : DONE;
    endcase
  end
  // bypassed requests spend one cycle in WAIT so their result appears one edge after accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_b       <= 1'b1;
      k            <= '0;
      w            <= '0;
      byp_q        <= 1'b0;
      res_frac     <= '0;
      res_src      <= 1'b0;
      res_sat      <= 1'b0;
      div_dividend <= '0;
      div_divider  <= '0;
    end else begin
      state <= state_n;
      k     <= (state == RUN) ? k + 3'd1 : 3'd0;
      w     <= (state == WAIT) ? w + 2'd1 : 2'd0;
      if (acc) begin
        last_b       <= gnt_b;
        res_src      <= gnt_b;
        byp_q        <= byp;
        div_dividend <= dvd;
        div_divider  <= dvs;
        res_frac     <= {FW{sat}};
        res_sat      <= sat;
      end
      if (cap) begin
        res_frac <= div_frac_val;
        res_sat  <= 1'b0;
      end
    end
  end
  assign div_cycle_cnt = k;
  assign res_valid     = (state == DONE);
  assign busy          = (state != IDLE);
endmodule
